uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Receive half of the UART: deserialises the UARTRXD line using the shared 16x baudClk enable.
- Checks parity, framing and break conditions, and writes each character plus its error flags into the RX FIFO.
- Frame format is shared with the transmit path and comes from UARTLCR_H/UARTCR fields: 5-8 data bits, LSB first, optional parity, stop bit(s).
- Status feeds UARTFR; the data word feeds the RX FIFO write port.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising UARTRXD into the CLK domain (minimum 2).

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  reset; synchronous, active-low. Clock is CLK.
- baudClk  input  1  one-CLK-cycle enable pulse at 16x the baud rate.
- UARTRXD  input  1  serial line, asynchronous, idles high.
- stick_parity_sel  input  1  UARTLCR_H[7].
- word_len  input  2  UARTLCR_H[6:5]; 00=5, 01=6, 10=7, 11=8 data bits.
- even_parity_sel  input  1  UARTLCR_H[2]; 1=even.
- parity_en  input  1  UARTLCR_H[1].
- rx_en  input  1  UARTCR[9].
- UART_en  input  1  UARTCR[0].
- fifo_full  input  1  RX FIFO cannot accept a write this cycle.
- fifo_wr  output  1  one-cycle write strobe to the RX FIFO.
- fifo_wdata  output  12  {oe, be, pe, fe, data[7:0]}; unused upper data bits are 0.
- rx_busy  output  1  to UARTFR; high from start-bit detect until the frame ends.

Behaviour:
- Reset (RSTn=0 at a CLK edge): state=IDLE; counters=0; shift data=0; overrun_pending=0; fifo_wr=0; fifo_wdata=0; rx_busy=0; all synchroniser flops=1.
- Reset mid-frame aborts the frame and performs no write.
- Counter update rule: counters advance only on CLK edges where baudClk=1. Config inputs are sampled live and are stable during a frame.
- Line sample: rxs = output of the synchroniser (SYNC_STAGES CLK of latency).
- IDLE:
  - If rx_en=0 or UART_en=0, go to DISABLE.
  - Else, on a baudClk tick with rxs=0: go to START, count16=0, rx_busy=1.
- DISABLE: go to IDLE when rx_en=1 and UART_en=1. Disabling mid-frame takes effect only after the frame completes.
- START: on each tick, count16++. At the tick where count16==7 (mid start bit):
  - rxs=1: false start. Go to IDLE, rx_busy=0, no write.
  - rxs=0: go to DATA with count16=0, count8=0, parity accumulator=0.
- DATA: on each tick, count16++. At count16==15 (16 ticks after the previous sample, i.e. mid-bit):
  - data[count8]=rxs; parity ^= rxs.
  - If count8 equals the last bit index (4/5/6/7 for word_len 00/01/10/11), go to PARITY if parity_en=1, else to STOP. Otherwise count8++.
  - count16 wraps to 0 in every case.
- PARITY: sample rxs at count16==15, then go to STOP.
  - Expected bit when stick_parity_sel=1: ~even_parity_sel.
  - Expected bit otherwise: parity_acc ^ ~even_parity_sel.
  - pe = sampled bit != expected bit.
- STOP: sample rxs at count16==15; fe = ~rxs. Only the first stop bit is checked; a second stop bit is treated as idle.
- Break condition: all data bits=0, parity bit=0 (when enabled) and stop bit=0. On break the written word is data=0, be=1, fe=0, pe=0. The state then goes to BRK_WAIT, otherwise to IDLE.
- BRK_WAIT: stays here until rxs=1 on a baudClk tick, then goes to IDLE. No further writes occur while the line is held low.
- Write timing:
  - fifo_wr pulses for exactly one CLK, registered, in the cycle after the stop-bit sample edge. fifo_wdata is valid in the same cycle and holds its value afterwards.
  - rx_busy falls in that same cycle.
- Overrun:
  - If fifo_full=1 at the write cycle, the character is dropped (no fifo_wr) and overrun_pending=1.
  - The next character actually written carries oe=1, then overrun_pending clears.
  - Repeated drops keep a single pending flag.
- Back-to-back frames: a start bit detected in IDLE immediately after the stop sample is accepted. Minimum frame gap is 0 bit-times.

Test Plan:
- 8N1, 0x55, ideal timing -> one fifo_wr with fifo_wdata=12'h055; rx_busy high for about 9.5 bit-times; no other writes.
- 7E1 with 0x41 and parity bit 1 (correct value is 0) -> fifo_wdata=12'h241 (pe=1). Repeat with parity bit 0 -> 12'h041. Stick parity, even_parity_sel=1, parity bit 1 -> pe=1.
- Line low for 4 baudClk ticks then high -> no fifo_wr; rx_busy pulses and returns to 0; receiver returns to IDLE.
- 5N1, data 0x1F, stop bit driven 0 -> fifo_wdata=12'h11F (fe=1), followed by normal reception of the next frame.
- Line held low for 3 frame-times, 8N1 -> exactly one write of 12'h400 (be=1); next frame 0xA5 after the line returns high -> 12'h0A5.
- fifo_full=1 during the write of 0x11, then 0 -> 0x11 dropped; next char 0x22 written as 12'h822 (oe=1); following char 0x33 written as 12'h033.
- Reset asserted mid-DATA -> fifo_wr stays 0 and rx_busy=0; the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_receiver_if.sv
// RX FIFO write port seen by the UART receiver: write strobe, 12-bit word, full back-pressure.
interface uart_receiver_if;
    logic        fifo_wr;
    logic [11:0] fifo_wdata;
    logic        fifo_full;

    modport master (
        output fifo_wr,
        output fifo_wdata,
        input  fifo_full
    );

    modport slave (
        input  fifo_wr,
        input  fifo_wdata,
        output fifo_full
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: oversamples UARTRXD on the 16x baudClk enable, checks parity, framing and
// break, and writes {oe, be, pe, fe, data[7:0]} into the RX FIFO.
module uart_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            baudClk,
    input  logic            UARTRXD,
    input  logic            stick_parity_sel,
    input  logic [1:0]      word_len,
    input  logic            even_parity_sel,
    input  logic            parity_en,
    input  logic            rx_en,
    input  logic            UART_en,
    uart_receiver_if.master fifo,
    output logic            rx_busy
);

    localparam int unsigned SyncN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        StIdle,
        StDisable,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  count16_q, count16_d;
    logic [2:0]  count8_q, count8_d;
    logic [7:0]  data_q, data_d;
    logic        par_acc_q, par_acc_d;
    logic        par_bit_q, par_bit_d;
    logic        pe_q, pe_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;
    logic        wr_q, wr_d;
    logic [11:0] wdata_q, wdata_d;
    logic [SyncN-1:0] sync_q;

    logic        rxs;
    logic        mid_bit;
    logic [2:0]  last_idx;
    logic [7:0]  data_mask;
    logic        exp_par;
    logic        brk;
    logic [11:0] word;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SyncN-2:0], UARTRXD};
        end
    end

    assign rxs      = sync_q[SyncN-1];
    assign mid_bit  = baudClk && (count16_q == 4'd15);
    assign last_idx = 3'd4 + {1'b0, word_len};
    assign exp_par  = stick_parity_sel ? ~even_parity_sel : (par_acc_q ^ ~even_parity_sel);

    always_comb begin
        unique case (word_len)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    end

    // par_bit_q is forced to 0 when parity is disabled, so it never blocks break detection.
    assign brk  = !rxs && ((data_q & data_mask) == 8'h00) && !par_bit_q;
    assign word = brk ? {ovr_q, 1'b1, 1'b0, 1'b0, 8'h00}
                      : {ovr_q, 1'b0, pe_q, ~rxs, data_q & data_mask};

    always_comb begin
        state_d   = state_q;
        count16_d = count16_q;
        count8_d  = count8_q;
        data_d    = data_q;
        par_acc_d = par_acc_q;
        par_bit_d = par_bit_q;
        pe_d      = pe_q;
        busy_d    = busy_q;
        ovr_d     = ovr_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;

        case (state_q)
            StIdle: begin
                if (!rx_en || !UART_en) begin
                    state_d = StDisable;
                end else if (baudClk && !rxs) begin
                    state_d   = StStart;
                    count16_d = 4'd0;
                    busy_d    = 1'b1;
                end
            end

            StDisable: begin
                if (rx_en && UART_en) begin
                    state_d = StIdle;
                end
            end

            StStart: begin
                if (baudClk) begin
                    if (count16_q == 4'd7) begin
                        count16_d = 4'd0;
                        if (rxs) begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end else begin
                            state_d   = StData;
                            count8_d  = 3'd0;
                            par_acc_d = 1'b0;
                            data_d    = 8'h00;
                        end
                    end else begin
                        count16_d = count16_q + 4'd1;
                    end
                end
            end

            StData: begin
                if (baudClk) begin
                    count16_d = count16_q + 4'd1;
                end
                if (mid_bit) begin
                    data_d[count8_q] = rxs;
                    par_acc_d        = par_acc_q ^ rxs;
                    if (count8_q == last_idx) begin
                        state_d   = parity_en ? StParity : StStop;
                        par_bit_d = 1'b0;
                        pe_d      = 1'b0;
                    end else begin
                        count8_d = count8_q + 3'd1;
                    end
                end
            end

            StParity: begin
                if (baudClk) begin
                    count16_d = count16_q + 4'd1;
                end
                if (mid_bit) begin
                    par_bit_d = rxs;
                    pe_d      = rxs ^ exp_par;
                    state_d   = StStop;
                end
            end

            StStop: begin
                if (baudClk) begin
                    count16_d = count16_q + 4'd1;
                end
                if (mid_bit) begin
                    busy_d  = 1'b0;
                    state_d = brk ? StBrkWait : StIdle;
                    // A full FIFO drops the character; the sticky flag rides on the next write.
                    if (fifo.fifo_full) begin
                        ovr_d = 1'b1;
                    end else begin
                        wr_d    = 1'b1;
                        wdata_d = word;
                        ovr_d   = 1'b0;
                    end
                end
            end

            StBrkWait: begin
                if (baudClk && rxs) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= StIdle;
            count16_q <= 4'd0;
            count8_q  <= 3'd0;
            data_q    <= 8'h00;
            par_acc_q <= 1'b0;
            par_bit_q <= 1'b0;
            pe_q      <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= 12'h000;
        end else begin
            state_q   <= state_d;
            count16_q <= count16_d;
            count8_q  <= count8_d;
            data_q    <= data_d;
            par_acc_q <= par_acc_d;
            par_bit_q <= par_bit_d;
            pe_q      <= pe_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign fifo.fifo_wr    = wr_q;
    assign fifo.fifo_wdata = wdata_q;
    assign rx_busy         = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven bit by bit, expected FIFO words are queued
// and matched against captured writes.
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;  // 16 baudClk ticks, one every 4 CLK

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       baudClk = 1'b0;
    logic [1:0] div = 2'd0;
    logic       UARTRXD = 1'b1;
    logic       stick_parity_sel = 1'b0;
    logic [1:0] word_len = 2'b11;
    logic       even_parity_sel = 1'b0;
    logic       parity_en = 1'b0;
    logic       rx_en = 1'b1;
    logic       UART_en = 1'b1;
    logic       rx_busy;

    uart_receiver_if rx_if ();

    uart_receiver #(
        .SYNC_STAGES(2)
    ) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .baudClk         (baudClk),
        .UARTRXD         (UARTRXD),
        .stick_parity_sel(stick_parity_sel),
        .word_len        (word_len),
        .even_parity_sel (even_parity_sel),
        .parity_en       (parity_en),
        .rx_en           (rx_en),
        .UART_en         (UART_en),
        .fifo            (rx_if),
        .rx_busy         (rx_busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        div     <= div + 2'd1;
        baudClk <= (div == 2'd3);
    end

    // Capture every write with a flag saying rx_busy fell in exactly that cycle.
    logic [12:0] obs_mem [0:63];
    int          wr_count = 0;
    int          busy_run = 0;
    int          last_busy_len = 0;
    logic        busy_prev = 1'b0;

    always @(negedge CLK) begin
        if (rx_if.fifo_wr === 1'b1) begin
            obs_mem[wr_count[5:0]] <= {(rx_busy === 1'b0) && (busy_prev === 1'b1),
                                       rx_if.fifo_wdata};
            wr_count <= wr_count + 1;
        end
        if (rx_busy === 1'b1) begin
            busy_run <= busy_run + 1;
        end else if (busy_prev === 1'b1) begin
            last_busy_len <= busy_run;
            busy_run      <= 0;
        end
        busy_prev <= rx_busy;
    end

    logic [11:0] exp_q[$];
    int          rd_idx = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic drain(input string tag);
        logic [12:0] o;
        logic [11:0] e;
        for (int i = 0; i < 4000; i++) begin
            if (wr_count - rd_idx >= exp_q.size()) break;
            @(posedge CLK);
        end
        while (rd_idx < wr_count) begin
            o = obs_mem[rd_idx[5:0]];
            rd_idx++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL %s unexpected write: observed %03h expected none", tag, o[11:0]);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({tag, " wdata"}, 32'(o[11:0]), 32'(e));
                check({tag, " busy_fall_with_wr"}, 32'(o[12]), 32'd1);
            end
        end
        check({tag, " missing_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic drive_bit(input logic b);
        #2 UARTRXD = b;
        repeat (BIT_CLKS) @(posedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                              input logic pbit, input logic stopb, input int idle);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stopb);
        repeat (idle) drive_bit(1'b1);
    endtask

    initial begin
        rx_if.fifo_full = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("reset fifo_wr", 32'(rx_if.fifo_wr), 32'd0);
        check("reset fifo_wdata", 32'(rx_if.fifo_wdata), 32'd0);
        check("reset rx_busy", 32'(rx_busy), 32'd0);
        @(posedge CLK);
        #2 RSTn = 1'b1;
        repeat (BIT_CLKS) @(posedge CLK);

        // 8N1 0x55
        exp_q.push_back(12'h055);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 2);
        drain("8n1_55");
        check_range("8n1 busy_len", last_busy_len, 9 * BIT_CLKS + 32 - 16, 9 * BIT_CLKS + 32 + 16);
        @(negedge CLK);
        check("8n1 busy_idle", 32'(rx_busy), 32'd0);

        // 7E1 0x41: wrong parity, right parity, then stick parity (expected 0)
        word_len = 2'b10; parity_en = 1'b1; even_parity_sel = 1'b1;
        exp_q.push_back(12'h241);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1);
        exp_q.push_back(12'h041);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1);
        stick_parity_sel = 1'b1;
        exp_q.push_back(12'h241);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1);
        drain("7e1");
        stick_parity_sel = 1'b0; parity_en = 1'b0; even_parity_sel = 1'b0; word_len = 2'b11;

        // False start: 4 ticks low
        #2 UARTRXD = 1'b0;
        repeat (16) @(posedge CLK);
        @(negedge CLK);
        check("false_start busy_high", 32'(rx_busy), 32'd1);
        @(posedge CLK);
        #2 UARTRXD = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge CLK);
        @(negedge CLK);
        check("false_start busy_low", 32'(rx_busy), 32'd0);
        drain("false_start");

        // 5N1 0x1F with framing error, then a normal 5-bit character
        word_len = 2'b00;
        exp_q.push_back(12'h11F);
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 2);
        exp_q.push_back(12'h00A);
        send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b1, 2);
        drain("5n1_fe");
        word_len = 2'b11;

        // Break: line low for 3 frame-times, then 0xA5
        @(posedge CLK);
        exp_q.push_back(12'h400);
        #2 UARTRXD = 1'b0;
        repeat (30 * BIT_CLKS) @(posedge CLK);
        drive_bit(1'b1);
        drive_bit(1'b1);
        exp_q.push_back(12'h0A5);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 2);
        drain("break");

        // Overrun: 0x11 dropped, 0x22 carries oe, 0x33 clean
        rx_if.fifo_full = 1'b1;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1);
        rx_if.fifo_full = 1'b0;
        exp_q.push_back(12'h822);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1);
        exp_q.push_back(12'h033);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1);
        drain("overrun");

        // Reset in the middle of the data bits
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        #2 UARTRXD = 1'b0;
        repeat (20) @(posedge CLK);
        #2 RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("mid_reset busy", 32'(rx_busy), 32'd0);
        check("mid_reset fifo_wr", 32'(rx_if.fifo_wr), 32'd0);
        @(posedge CLK);
        #2 RSTn = 1'b1;
        UARTRXD = 1'b1;
        repeat (12 * BIT_CLKS) @(posedge CLK);
        @(negedge CLK);
        check("post_reset busy", 32'(rx_busy), 32'd0);
        @(posedge CLK);
        exp_q.push_back(12'h03C);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 2);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
